// File: rtl/or1k_spr_cfg_access_if.sv
// SPR bus between the SPR access unit (master) and the SPR bus fabric (slave).
// Single outstanding access: strobe held until a one-cycle acknowledge.
interface or1k_spr_cfg_access_if;
   logic        spr_bus_stb_o;
   logic        spr_bus_we_o;
   logic [15:0] spr_bus_addr_o;
   logic [31:0] spr_bus_dat_o;
   logic        spr_bus_ack_i;
   logic [31:0] spr_bus_dat_i;

   modport master (
      output spr_bus_stb_o,
      output spr_bus_we_o,
      output spr_bus_addr_o,
      output spr_bus_dat_o,
      input  spr_bus_ack_i,
      input  spr_bus_dat_i
   );

   modport slave (
      input  spr_bus_stb_o,
      input  spr_bus_we_o,
      input  spr_bus_addr_o,
      input  spr_bus_dat_o,
      output spr_bus_ack_i,
      output spr_bus_dat_i
   );
endinterface

// File: rtl/or1k_spr_cfg_access.sv
// Requester-side SPR access unit: group-0 reads served from configuration inputs,
// other groups forwarded to the SPR bus. Optional bus timeout: OR1K_SPR_BUS_TIMEOUT_EN.
module or1k_spr_cfg_access #(
   parameter int SPR_BUS_TIMEOUT = 255
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst_n,
   input  logic        req_i,
   input  logic        req_we_i,
   input  logic [15:0] req_addr_i,
   input  logic [31:0] req_wdat_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdat_o,
   output logic        err_o,
   input  logic [31:0] spr_vr,
   input  logic [31:0] spr_vr2,
   input  logic [31:0] spr_upr,
   input  logic [31:0] spr_cpucfgr,
   input  logic [31:0] spr_dmmucfgr,
   input  logic [31:0] spr_immucfgr,
   input  logic [31:0] spr_dccfgr,
   input  logic [31:0] spr_iccfgr,
   input  logic [31:0] spr_dcfgr,
   input  logic [31:0] spr_pccfgr,
   input  logic [31:0] spr_avr,
   or1k_spr_cfg_access_if.master spr_bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CFG  = 2'd1,
      BUS  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdat_q, wdat_d;
   logic        stb_q, stb_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] rdat_q, rdat_d;
   logic [31:0] cfg_rdat;

`ifdef OR1K_SPR_BUS_TIMEOUT_EN
   localparam int CNT_W = (SPR_BUS_TIMEOUT > 256) ? $clog2(SPR_BUS_TIMEOUT) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = (SPR_BUS_TIMEOUT != 0);
`endif

   // Configuration register file view, indexed by the captured group-0 index.
   always_comb begin
      cfg_rdat = 32'd0;
      case (addr_q[10:0])
         11'd0:   cfg_rdat = spr_vr;
         11'd1:   cfg_rdat = spr_upr;
         11'd2:   cfg_rdat = spr_cpucfgr;
         11'd3:   cfg_rdat = spr_dmmucfgr;
         11'd4:   cfg_rdat = spr_immucfgr;
         11'd5:   cfg_rdat = spr_dccfgr;
         11'd6:   cfg_rdat = spr_iccfgr;
         11'd7:   cfg_rdat = spr_dcfgr;
         11'd8:   cfg_rdat = spr_pccfgr;
         11'd9:   cfg_rdat = spr_vr2;
         11'd10:  cfg_rdat = spr_avr;
         default: cfg_rdat = 32'd0;
      endcase
   end

   // Next-state and registered-output logic; outputs are flopped so the bus
   // strobe and completion pulse are glitch-free.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      stb_d   = stb_q;
      done_d  = 1'b0;
      err_d   = err_q;
      rdat_d  = rdat_q;
`ifdef OR1K_SPR_BUS_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_i) begin
               we_d   = req_we_i;
               addr_d = req_addr_i;
               wdat_d = req_wdat_i;
               if (req_addr_i[15:11] == 5'd0) begin
                  state_d = CFG;
               end else begin
                  state_d = BUS;
                  stb_d   = 1'b1;
`ifdef OR1K_SPR_BUS_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         CFG: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (we_q) begin
               rdat_d = 32'd0;
               err_d  = 1'b1;
            end else begin
               rdat_d = cfg_rdat;
               err_d  = 1'b0;
            end
         end
         BUS: begin
            // An ack on the terminal timeout cycle still completes normally.
            if (spr_bus.spr_bus_ack_i) begin
               state_d = IDLE;
               stb_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b0;
               rdat_d  = we_q ? 32'd0 : spr_bus.spr_bus_dat_i;
            end
`ifdef OR1K_SPR_BUS_TIMEOUT_EN
            else if (cnt_q == CNT_W'(SPR_BUS_TIMEOUT - 1)) begin
               state_d = IDLE;
               stb_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               rdat_d  = 32'd0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            stb_d   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any access in flight.
   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= 16'd0;
         wdat_q  <= 32'd0;
         stb_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= 32'd0;
`ifdef OR1K_SPR_BUS_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         stb_q   <= stb_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
`ifdef OR1K_SPR_BUS_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign busy_o                 = (state_q != IDLE);
   assign done_o                 = done_q;
   assign err_o                  = err_q;
   assign rdat_o                 = rdat_q;
   assign spr_bus.spr_bus_stb_o  = stb_q;
   assign spr_bus.spr_bus_we_o   = we_q;
   assign spr_bus.spr_bus_addr_o = addr_q;
   assign spr_bus.spr_bus_dat_o  = wdat_q;

endmodule

// File: tb/tb_or1k_spr_cfg_access.sv
// Directed self-checking bench for or1k_spr_cfg_access; timeout scenario runs
// when OR1K_SPR_BUS_TIMEOUT_EN is defined (SPR_BUS_TIMEOUT = 4).
module tb_or1k_spr_cfg_access;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst_n = 1'b0;
   logic        req_i = 1'b0;
   logic        req_we_i = 1'b0;
   logic [15:0] req_addr_i = 16'd0;
   logic [31:0] req_wdat_i = 32'd0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] rdat_o;
   logic        err_o;
   logic [31:0] spr_vr       = 32'h1200_0001;
   logic [31:0] spr_vr2      = 32'h0100_0002;
   logic [31:0] spr_upr      = 32'h0000_0705;
   logic [31:0] spr_cpucfgr  = 32'h0000_3620;
   logic [31:0] spr_dmmucfgr = 32'h0000_0018;
   logic [31:0] spr_immucfgr = 32'h0000_0019;
   logic [31:0] spr_dccfgr   = 32'h0000_00A3;
   logic [31:0] spr_iccfgr   = 32'h0000_00A4;
   logic [31:0] spr_dcfgr    = 32'h0000_0008;
   logic [31:0] spr_pccfgr   = 32'h0000_0001;
   logic [31:0] spr_avr      = 32'h0102_0300;

   int total = 0;
   int bad = 0;

   or1k_spr_cfg_access_if bus_if ();

   or1k_spr_cfg_access #(.SPR_BUS_TIMEOUT(4)) dut (
      .cpu_clk      (cpu_clk),
      .cpu_rst_n    (cpu_rst_n),
      .req_i        (req_i),
      .req_we_i     (req_we_i),
      .req_addr_i   (req_addr_i),
      .req_wdat_i   (req_wdat_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .rdat_o       (rdat_o),
      .err_o        (err_o),
      .spr_vr       (spr_vr),
      .spr_vr2      (spr_vr2),
      .spr_upr      (spr_upr),
      .spr_cpucfgr  (spr_cpucfgr),
      .spr_dmmucfgr (spr_dmmucfgr),
      .spr_immucfgr (spr_immucfgr),
      .spr_dccfgr   (spr_dccfgr),
      .spr_iccfgr   (spr_iccfgr),
      .spr_dcfgr    (spr_dcfgr),
      .spr_pccfgr   (spr_pccfgr),
      .spr_avr      (spr_avr),
      .spr_bus      (bus_if.master)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Presents a one-cycle request, returning at the negedge of cycle N+1.
   task automatic apply_request(input logic we, input logic [15:0] addr, input logic [31:0] wdat);
      @(negedge cpu_clk);
      req_i      = 1'b1;
      req_we_i   = we;
      req_addr_i = addr;
      req_wdat_i = wdat;
      @(negedge cpu_clk);
      req_i    = 1'b0;
      req_we_i = 1'b0;
   endtask

   task automatic test_reset();
      bus_if.spr_bus_ack_i = 1'b0;
      bus_if.spr_bus_dat_i = 32'd0;
      cpu_rst_n = 1'b0;
      repeat (2) @(negedge cpu_clk);
      total++; if (done_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done_o); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", err_o); end
      total++; if (rdat_o !== 32'd0) begin bad++; $display("[TB] FAIL reset_rdat got=%h want=0", rdat_o); end
      total++; if (bus_if.spr_bus_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_stb got=%b want=0", bus_if.spr_bus_stb_o); end
      total++; if (bus_if.spr_bus_we_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%b want=0", bus_if.spr_bus_we_o); end
      total++; if (bus_if.spr_bus_addr_o !== 16'd0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", bus_if.spr_bus_addr_o); end
      total++; if (bus_if.spr_bus_dat_o !== 32'd0) begin bad++; $display("[TB] FAIL reset_dat got=%h want=0", bus_if.spr_bus_dat_o); end
      cpu_rst_n = 1'b1;
   endtask

   task automatic test_cfg_read();
      logic [15:0] addrs [6] = '{16'h0000, 16'h000B, 16'h0009, 16'h000A, 16'h07FF, 16'h0002};
      logic [31:0] exps  [6] = '{32'h1200_0001, 32'h0, 32'h0100_0002, 32'h0102_0300, 32'h0, 32'h0000_3620};
      for (int i = 0; i < 6; i++) begin
         apply_request(1'b0, addrs[i], 32'd0);
         total++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin bad++; $display("[TB] FAIL cfg_read_n1 addr=%h busy=%b done=%b want busy=1 done=0", addrs[i], busy_o, done_o); end
         total++; if (bus_if.spr_bus_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL cfg_read_stb addr=%h got=%b want=0", addrs[i], bus_if.spr_bus_stb_o); end
         @(negedge cpu_clk);
         total++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL cfg_read_n2 addr=%h done=%b busy=%b want done=1 busy=0", addrs[i], done_o, busy_o); end
         total++; if (rdat_o !== exps[i]) begin bad++; $display("[TB] FAIL cfg_read_rdat addr=%h got=%h want=%h", addrs[i], rdat_o, exps[i]); end
         total++; if (err_o !== 1'b0) begin bad++; $display("[TB] FAIL cfg_read_err addr=%h got=%b want=0", addrs[i], err_o); end
         total++; if (bus_if.spr_bus_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL cfg_read_stb2 addr=%h got=%b want=0", addrs[i], bus_if.spr_bus_stb_o); end
      end
   endtask

   task automatic test_cfg_write();
      apply_request(1'b1, 16'h0001, 32'hFFFF_FFFF);
      total++; if (done_o !== 1'b0 || bus_if.spr_bus_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL cfg_write_n1 done=%b stb=%b want 0 0", done_o, bus_if.spr_bus_stb_o); end
      @(negedge cpu_clk);
      total++; if (done_o !== 1'b1) begin bad++; $display("[TB] FAIL cfg_write_done got=%b want=1", done_o); end
      total++; if (err_o !== 1'b1) begin bad++; $display("[TB] FAIL cfg_write_err got=%b want=1", err_o); end
      total++; if (rdat_o !== 32'd0) begin bad++; $display("[TB] FAIL cfg_write_rdat got=%h want=0", rdat_o); end
      total++; if (bus_if.spr_bus_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL cfg_write_stb got=%b want=0", bus_if.spr_bus_stb_o); end
   endtask

   task automatic test_bus_read();
      // Stray ack while idle must not produce a completion
      @(negedge cpu_clk);
      bus_if.spr_bus_ack_i = 1'b1;
      bus_if.spr_bus_dat_i = 32'h1111_1111;
      @(negedge cpu_clk);
      bus_if.spr_bus_ack_i = 1'b0;
      total++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL idle_ack done=%b busy=%b want 0 0", done_o, busy_o); end

      apply_request(1'b0, 16'h2801, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         total++; if (bus_if.spr_bus_stb_o !== 1'b1 || done_o !== 1'b0) begin bad++; $display("[TB] FAIL bus_read_wait k=%0d stb=%b done=%b want 1 0", k, bus_if.spr_bus_stb_o, done_o); end
         total++; if (bus_if.spr_bus_addr_o !== 16'h2801 || bus_if.spr_bus_we_o !== 1'b0) begin bad++; $display("[TB] FAIL bus_read_addr k=%0d addr=%h we=%b want 2801 0", k, bus_if.spr_bus_addr_o, bus_if.spr_bus_we_o); end
         if (k == 3) begin
            bus_if.spr_bus_ack_i = 1'b1;
            bus_if.spr_bus_dat_i = 32'hDEAD_BEEF;
         end
         @(negedge cpu_clk);
      end
      bus_if.spr_bus_ack_i = 1'b0;
      bus_if.spr_bus_dat_i = 32'd0;
      total++; if (done_o !== 1'b1 || bus_if.spr_bus_stb_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL bus_read_done done=%b stb=%b busy=%b want 1 0 0", done_o, bus_if.spr_bus_stb_o, busy_o); end
      total++; if (rdat_o !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL bus_read_rdat got=%h want=deadbeef", rdat_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("[TB] FAIL bus_read_err got=%b want=0", err_o); end

      apply_request(1'b1, 16'h0801, 32'h1234_5678);
      total++; if (bus_if.spr_bus_stb_o !== 1'b1 || bus_if.spr_bus_we_o !== 1'b1) begin bad++; $display("[TB] FAIL bus_write_stb stb=%b we=%b want 1 1", bus_if.spr_bus_stb_o, bus_if.spr_bus_we_o); end
      total++; if (bus_if.spr_bus_addr_o !== 16'h0801 || bus_if.spr_bus_dat_o !== 32'h1234_5678) begin bad++; $display("[TB] FAIL bus_write_fields addr=%h dat=%h want 0801 12345678", bus_if.spr_bus_addr_o, bus_if.spr_bus_dat_o); end
      bus_if.spr_bus_ack_i = 1'b1;
      bus_if.spr_bus_dat_i = 32'hAAAA_5555;
      @(negedge cpu_clk);
      bus_if.spr_bus_ack_i = 1'b0;
      total++; if (done_o !== 1'b1 || err_o !== 1'b0 || rdat_o !== 32'd0) begin bad++; $display("[TB] FAIL bus_write_done done=%b err=%b rdat=%h want 1 0 0", done_o, err_o, rdat_o); end
   endtask

   task automatic test_back_to_back();
      int done_count;
      apply_request(1'b0, 16'h2002, 32'd0);
      req_i      = 1'b1;
      req_we_i   = 1'b1;
      req_addr_i = 16'h3003;
      total++; if (bus_if.spr_bus_addr_o !== 16'h2002 || busy_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first addr=%h busy=%b want 2002 1", bus_if.spr_bus_addr_o, busy_o); end
      @(negedge cpu_clk);
      total++; if (bus_if.spr_bus_addr_o !== 16'h2002 || bus_if.spr_bus_we_o !== 1'b0 || bus_if.spr_bus_stb_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_hold addr=%h we=%b stb=%b want 2002 0 1", bus_if.spr_bus_addr_o, bus_if.spr_bus_we_o, bus_if.spr_bus_stb_o); end
      @(negedge cpu_clk);
      req_i    = 1'b0;
      req_we_i = 1'b0;
      total++; if (bus_if.spr_bus_addr_o !== 16'h2002) begin bad++; $display("[TB] FAIL b2b_hold2 addr=%h want 2002", bus_if.spr_bus_addr_o); end
      bus_if.spr_bus_ack_i = 1'b1;
      bus_if.spr_bus_dat_i = 32'h5A5A_0F0F;
      @(negedge cpu_clk);
      bus_if.spr_bus_ack_i = 1'b0;
      total++; if (done_o !== 1'b1 || rdat_o !== 32'h5A5A_0F0F) begin bad++; $display("[TB] FAIL b2b_done done=%b rdat=%h want 1 5a5a0f0f", done_o, rdat_o); end
      done_count = int'(done_o);
      for (int k = 0; k < 4; k++) begin
         @(negedge cpu_clk);
         done_count += int'(done_o);
      end
      total++; if (done_count != 1) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=1", done_count); end
      total++; if (busy_o !== 1'b0 || bus_if.spr_bus_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle busy=%b stb=%b want 0 0", busy_o, bus_if.spr_bus_stb_o); end
   endtask

`ifdef OR1K_SPR_BUS_TIMEOUT_EN
   task automatic test_timeout();
      apply_request(1'b0, 16'h1000, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         total++; if (bus_if.spr_bus_stb_o !== 1'b1 || done_o !== 1'b0) begin bad++; $display("[TB] FAIL timeout_wait k=%0d stb=%b done=%b want 1 0", k, bus_if.spr_bus_stb_o, done_o); end
         @(negedge cpu_clk);
      end
      total++; if (done_o !== 1'b1 || bus_if.spr_bus_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL timeout_done done=%b stb=%b want 1 0", done_o, bus_if.spr_bus_stb_o); end
      total++; if (err_o !== 1'b1 || rdat_o !== 32'd0) begin bad++; $display("[TB] FAIL timeout_err err=%b rdat=%h want 1 0", err_o, rdat_o); end

      apply_request(1'b0, 16'h1004, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         if (k == 4) begin
            bus_if.spr_bus_ack_i = 1'b1;
            bus_if.spr_bus_dat_i = 32'hCAFE_0001;
         end
         @(negedge cpu_clk);
      end
      bus_if.spr_bus_ack_i = 1'b0;
      total++; if (done_o !== 1'b1 || err_o !== 1'b0 || rdat_o !== 32'hCAFE_0001) begin bad++; $display("[TB] FAIL timeout_ack_wins done=%b err=%b rdat=%h want 1 0 cafe0001", done_o, err_o, rdat_o); end
   endtask
`else
   task automatic test_no_timeout();
      logic stalled_ok;
      stalled_ok = 1'b1;
      apply_request(1'b0, 16'h1000, 32'd0);
      for (int k = 0; k < 20; k++) begin
         if (bus_if.spr_bus_stb_o !== 1'b1 || done_o !== 1'b0) stalled_ok = 1'b0;
         @(negedge cpu_clk);
      end
      total++; if (stalled_ok !== 1'b1) begin bad++; $display("[TB] FAIL no_timeout_wait got=%b want=1", stalled_ok); end
      bus_if.spr_bus_ack_i = 1'b1;
      bus_if.spr_bus_dat_i = 32'hCAFE_0001;
      @(negedge cpu_clk);
      bus_if.spr_bus_ack_i = 1'b0;
      total++; if (done_o !== 1'b1 || err_o !== 1'b0 || rdat_o !== 32'hCAFE_0001) begin bad++; $display("[TB] FAIL no_timeout_done done=%b err=%b rdat=%h want 1 0 cafe0001", done_o, err_o, rdat_o); end
   endtask
`endif

   task automatic test_reset_mid();
      apply_request(1'b0, 16'h2801, 32'd0);
      @(negedge cpu_clk);
      total++; if (bus_if.spr_bus_stb_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_stb_before got=%b want=1", bus_if.spr_bus_stb_o); end
      #2 cpu_rst_n = 1'b0;
      #1;
      total++; if (bus_if.spr_bus_stb_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_async stb=%b busy=%b done=%b want 0 0 0", bus_if.spr_bus_stb_o, busy_o, done_o); end
      total++; if (rdat_o !== 32'd0) begin bad++; $display("[TB] FAIL rst_mid_rdat got=%h want=0", rdat_o); end
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;
      apply_request(1'b0, 16'h0002, 32'd0);
      total++; if (busy_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_busy got=%b want=1", busy_o); end
      @(negedge cpu_clk);
      total++; if (done_o !== 1'b1 || rdat_o !== 32'h0000_3620 || err_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_read done=%b rdat=%h err=%b want 1 00003620 0", done_o, rdat_o, err_o); end
   endtask

   initial begin
      test_reset();
      test_cfg_read();
      test_cfg_write();
      test_bus_read();
      test_back_to_back();
`ifdef OR1K_SPR_BUS_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid();
      repeat (2) @(negedge cpu_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
